// File: rtl/cpu_types_pkg.sv
// Shared CPU types: instruction-cache address split, frame layout and FSM state.
package cpu_types_pkg;

    localparam int ICACHE_SETS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_SETS);
    localparam int ICACHE_TAG_W = 32 - ICACHE_IDX_W - 2;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        logic [31:0]             data;
    } icache_frame_t;

    typedef enum logic {
        IDLE = 1'b0,
        MISS = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache.sv
// Direct-mapped read-only instruction cache, one word per frame.
// Hits return combinationally; a miss issues one word read and fills on iwait=0.
module icache
    import cpu_types_pkg::*;
#(
    parameter int SETS = 16
) (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        imemREN,
    input  logic [31:0] imemaddr,
    output logic        ihit,
    output logic [31:0] imemload,
    input  logic        flush,
    output logic        iREN,
    output logic [31:0] iaddr,
    input  logic        iwait,
    input  logic [31:0] iload
);

    localparam int IDX_W = $clog2(SETS);
    localparam int TAG_W = 32 - IDX_W - 2;

    icache_state_t state_q, state_d;
    logic [31:2]   miss_q, miss_d;

    logic [SETS-1:0]  valid_q;
    logic [TAG_W-1:0] tag_q  [SETS];
    logic [31:0]      data_q [SETS];

    logic [IDX_W-1:0] idx;
    logic [TAG_W-1:0] tag;
    logic [IDX_W-1:0] fidx;
    logic             hit;
    logic             fill;
    logic             unused_bytoff;

    assign idx  = imemaddr[IDX_W+1:2];
    assign tag  = imemaddr[31:IDX_W+2];
    assign fidx = miss_q[IDX_W+1:2];
    assign unused_bytoff = ^imemaddr[1:0];

    // A flush in flight suppresses both the hit and any fill landing on the same edge.
    assign hit  = imemREN & valid_q[idx] & (tag_q[idx] == tag) & ~flush;
    assign fill = (state_q == MISS) & ~iwait & ~flush;

    always_comb begin
        state_d  = state_q;
        miss_d   = miss_q;
        ihit     = 1'b0;
        imemload = '0;
        iREN     = 1'b0;
        iaddr    = '0;
        unique case (state_q)
            IDLE: begin
                ihit = hit;
                if (hit) begin
                    imemload = data_q[idx];
                end
                if (imemREN && !hit) begin
                    miss_d  = imemaddr[31:2];
                    state_d = MISS;
                end
            end
            MISS: begin
                iREN  = 1'b1;
                iaddr = {miss_q, 2'b00};
                if (!iwait || flush) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= IDLE;
            miss_q  <= '0;
        end else begin
            state_q <= state_d;
            miss_q  <= miss_d;
        end
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            valid_q <= '0;
            for (int i = 0; i < SETS; i++) begin
                tag_q[i]  <= '0;
                data_q[i] <= '0;
            end
        end else if (flush) begin
            valid_q <= '0;
        end else if (fill) begin
            valid_q[fidx] <= 1'b1;
            tag_q[fidx]   <= miss_q[31:IDX_W+2];
            data_q[fidx]  <= iload;
        end
    end

endmodule

// File: tb/tb_icache.sv
// Directed bench for icache: table of fetches plus hand sequences
// for address change mid-miss, flush and reset during a miss.
module tb_icache;

    logic        CLK;
    logic        nRST;
    logic        imemREN;
    logic [31:0] imemaddr;
    logic        ihit;
    logic [31:0] imemload;
    logic        flush;
    logic        iREN;
    logic [31:0] iaddr;
    logic        iwait;
    logic [31:0] iload;

    int n_total;
    int n_pass;

    icache dut (
        .CLK      (CLK),
        .nRST     (nRST),
        .imemREN  (imemREN),
        .imemaddr (imemaddr),
        .ihit     (ihit),
        .imemload (imemload),
        .flush    (flush),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iwait    (iwait),
        .iload    (iload)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [31:0] addr;
        int          nwait;
        logic [31:0] data;
        bit          miss;
    } vec_t;

    vec_t vecs[11];

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic fetch(input vec_t v);
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = v.addr;
        iwait    = 1'b1;
        #1;
        if (!v.miss) begin
            chk("hit_ihit", {31'b0, ihit}, 32'd1);
            chk("hit_data", imemload, v.data);
            chk("hit_iren", {31'b0, iREN}, 32'd0);
        end else begin
            chk("miss_ihit", {31'b0, ihit}, 32'd0);
            for (int i = 0; i <= v.nwait; i++) begin
                @(negedge CLK);
                chk("miss_iren", {31'b0, iREN}, 32'd1);
                chk("miss_iaddr", iaddr, {v.addr[31:2], 2'b00});
                if (i == v.nwait) begin
                    iwait = 1'b0;
                    iload = v.data;
                end
            end
            @(negedge CLK);
            iwait = 1'b1;
            iload = '0;
            #1;
            chk("fill_ihit", {31'b0, ihit}, 32'd1);
            chk("fill_data", imemload, v.data);
            chk("fill_iren", {31'b0, iREN}, 32'd0);
        end
    endtask

    function automatic vec_t mk(input logic [31:0] a, input int w,
                                input logic [31:0] d, input bit m);
        vec_t v;
        v.addr  = a;
        v.nwait = w;
        v.data  = d;
        v.miss  = m;
        return v;
    endfunction

    initial begin
        n_total  = 0;
        n_pass   = 0;
        nRST     = 1'b0;
        imemREN  = 1'b0;
        imemaddr = '0;
        flush    = 1'b0;
        iwait    = 1'b1;
        iload    = '0;

        vecs[0]  = mk(32'h0000_0040, 2, 32'h8C01_0004, 1'b1);
        vecs[1]  = mk(32'h0000_0040, 0, 32'h8C01_0004, 1'b0);
        vecs[2]  = mk(32'h0000_0042, 0, 32'h8C01_0004, 1'b0);
        vecs[3]  = mk(32'h0000_0440, 1, 32'h1111_0440, 1'b1);
        vecs[4]  = mk(32'h0000_0440, 0, 32'h1111_0440, 1'b0);
        vecs[5]  = mk(32'h0000_0040, 0, 32'h8C01_0004, 1'b1);
        vecs[6]  = mk(32'h0000_0044, 3, 32'h2222_0044, 1'b1);
        vecs[7]  = mk(32'h0000_0040, 0, 32'h8C01_0004, 1'b0);
        vecs[8]  = mk(32'h0000_0044, 0, 32'h2222_0044, 1'b0);
        vecs[9]  = mk(32'hFFFF_FFFC, 1, 32'hDEAD_BEEF, 1'b1);
        vecs[10] = mk(32'hFFFF_FFFC, 0, 32'hDEAD_BEEF, 1'b0);

        @(negedge CLK);
        #1;
        chk("rst_ihit", {31'b0, ihit}, 32'd0);
        chk("rst_load", imemload, 32'd0);
        chk("rst_iren", {31'b0, iREN}, 32'd0);
        chk("rst_iaddr", iaddr, 32'd0);
        nRST = 1'b1;

        for (int i = 0; i < 11; i++) fetch(vecs[i]);

        // address change while the miss is outstanding
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h10;
        @(negedge CLK);
        imemaddr = 32'h20;
        #1;
        chk("chg_iaddr0", iaddr, 32'h10);
        @(negedge CLK);
        chk("chg_iaddr1", iaddr, 32'h10);
        iwait = 1'b0;
        iload = 32'hAAAA_0010;
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        chk("chg_newmiss", {31'b0, ihit}, 32'd0);
        chk("chg_iren0", {31'b0, iREN}, 32'd0);
        @(negedge CLK);
        chk("chg_iaddr2", iaddr, 32'h20);
        iwait = 1'b0;
        iload = 32'hBBBB_0020;
        @(negedge CLK);
        iwait = 1'b1;
        #1;
        chk("chg_hit20", imemload, 32'hBBBB_0020);
        imemaddr = 32'h10;
        #1;
        chk("chg_hit10", imemload, 32'hAAAA_0010);

        // flush in IDLE
        fetch(mk(32'h0, 0, 32'h0000_1000, 1'b1));
        fetch(mk(32'h4, 1, 32'h0000_1004, 1'b1));
        fetch(mk(32'h8, 0, 32'h0000_1008, 1'b1));
        #1;
        flush = 1'b1;
        #1;
        chk("fl_ihit", {31'b0, ihit}, 32'd0);
        chk("fl_load", imemload, 32'd0);
        imemREN = 1'b0;
        @(negedge CLK);
        flush = 1'b0;
        fetch(mk(32'h0, 0, 32'h0000_2000, 1'b1));
        fetch(mk(32'h4, 0, 32'h0000_2004, 1'b1));
        fetch(mk(32'h8, 0, 32'h0000_2008, 1'b1));

        // flush in MISS coinciding with the returning word
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h30;
        @(negedge CLK);
        chk("flm_iren1", {31'b0, iREN}, 32'd1);
        iwait = 1'b0;
        iload = 32'h3333_0030;
        flush = 1'b1;
        @(negedge CLK);
        flush = 1'b0;
        iwait = 1'b1;
        #1;
        chk("flm_iren0", {31'b0, iREN}, 32'd0);
        chk("flm_ihit", {31'b0, ihit}, 32'd0);
        @(negedge CLK);
        imemREN = 1'b0;
        iwait   = 1'b0;
        iload   = 32'h3333_3030;
        @(negedge CLK);
        iwait    = 1'b1;
        imemREN  = 1'b1;
        imemaddr = 32'h0;
        #1;
        chk("flm_cleared", {31'b0, ihit}, 32'd0);
        imemREN = 1'b0;
        fetch(mk(32'h30, 0, 32'h3333_3030, 1'b0));

        // reset while a miss is outstanding
        @(negedge CLK);
        imemaddr = 32'h50;
        @(negedge CLK);
        chk("rm_iren1", {31'b0, iREN}, 32'd1);
        #2;
        nRST = 1'b0;
        #1;
        chk("rm_iren0", {31'b0, iREN}, 32'd0);
        chk("rm_iaddr", iaddr, 32'd0);
        imemREN = 1'b0;
        #1;
        nRST = 1'b1;
        @(negedge CLK);
        imemREN  = 1'b1;
        imemaddr = 32'h30;
        #1;
        chk("rm_empty", {31'b0, ihit}, 32'd0);
        imemREN = 1'b0;
        @(negedge CLK);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
